mpx_regfile_mp: RTL and testbench

Parametrised multi-port register file for the MPX pipeline: NUM_RD asynchronous read ports and two independent write ports (ALU/writeback and load/multiply-divide return). Write-port multiplexing uses a live-value table (LVT) over two single-write banks. The block also provides optional same-cycle write-to-read bypass and a post-reset hardware clear sequencer, so the core never reads uninitialised register state.

---
 rtl/mpx_regfile_mp_pkg.sv | 19 +
 rtl/mpx_regfile_bank.sv | 31 +++
 rtl/mpx_regfile_mp.sv | 154 +++++++++++++++
 tb/tb_mpx_regfile_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpx_regfile_mp_pkg.sv
// Shared definitions for the MPX multi-port register file: default
// geometry and the clear-sequencer state encoding.
package mpx_regfile_mp_pkg;

    localparam int MPX_REG_W      = 32;
    localparam int MPX_REG_ADDR_W = 5;

    // INIT walks the clear counter over every entry; READY is normal operation.
    typedef enum logic {
        MPX_RF_INIT  = 1'b0,
        MPX_RF_READY = 1'b1
    } rf_state_e;

    // True when the entry at this address is the hard-wired zero register.
    function automatic logic is_zero_reg(input logic zero_en, input logic addr_nz);
        return zero_en && !addr_nz;
    endfunction

endpackage

// File: rtl/mpx_regfile_bank.sv
// Single-write, multi-read storage bank. Reads are asynchronous, and the
// array is not reset: the clear sequencer in the top level initialises it.
module mpx_regfile_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port into the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar n = 0; n < NUM_RD; n++) begin : g_rd
        assign rd_data[n*DATA_W +: DATA_W] = mem[rd_addr[n*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/mpx_regfile_mp.sv
// Two-write / NUM_RD-read register file built from two single-write banks
// and a live-value table (LVT). A post-reset sequencer zeroes every entry
// before the core is allowed to read or write.
module mpx_regfile_mp
    import mpx_regfile_mp_pkg::*;
#(
    parameter int DATA_W   = MPX_REG_W,
    parameter int ADDR_W   = MPX_REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr0_en_i,
    input  logic [ADDR_W-1:0]          wr0_addr_i,
    input  logic [DATA_W-1:0]          wr0_data_i,
    input  logic                       wr1_en_i,
    input  logic [ADDR_W-1:0]          wr1_addr_i,
    input  logic [DATA_W-1:0]          wr1_data_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic                       init_busy_o
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST     = '1;
    localparam logic              ZERO_EN  = (ZERO_REG != 0);
    localparam logic              BYP_EN   = (BYPASS != 0);

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_q;
    logic              ready;
    logic              clearing;
    logic              wr0_ok;
    logic              wr1_ok;
    logic [DEPTH-1:0]  lvt;

    logic                     b0_we;
    logic [ADDR_W-1:0]        b0_addr;
    logic [DATA_W-1:0]        b0_data;
    logic [NUM_RD*DATA_W-1:0] b0_rd;
    logic [NUM_RD*DATA_W-1:0] b1_rd;

    // Clear sequencer: reset always restarts the sweep at entry 0, and the
    // counter parks on the last entry rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= MPX_RF_INIT;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                MPX_RF_INIT: begin
                    if (clr_cnt == LAST) begin
                        state  <= MPX_RF_READY;
                        busy_q <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                MPX_RF_READY: begin
                    state <= MPX_RF_READY;
                end
                default: begin
                    state   <= MPX_RF_INIT;
                    clr_cnt <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // rst_i gates user traffic combinationally so a reset asserted while
    // READY blocks writes and blanks reads in that same cycle.
    assign ready       = (state == MPX_RF_READY) && !rst_i;
    assign clearing    = (state == MPX_RF_INIT) && !rst_i;
    assign init_busy_o = busy_q | rst_i;

    // Writes to the zero register are dropped before touching bank or LVT.
    assign wr0_ok = ready && wr0_en_i && !is_zero_reg(ZERO_EN, |wr0_addr_i);
    assign wr1_ok = ready && wr1_en_i && !is_zero_reg(ZERO_EN, |wr1_addr_i);

    // Bank0 is shared between the sequencer (zero fill) and write port 0.
    assign b0_we   = clearing | wr0_ok;
    assign b0_addr = clearing ? clr_cnt : wr0_addr_i;
    assign b0_data = clearing ? '0 : wr0_data_i;

    // LVT update: clearing points every entry at bank0; port 1 is applied
    // last so it wins an address collision with port 0.
    always_ff @(posedge clk_i) begin
        if (clearing) begin
            lvt[clr_cnt] <= 1'b0;
        end else begin
            if (wr0_ok) lvt[wr0_addr_i] <= 1'b0;
            if (wr1_ok) lvt[wr1_addr_i] <= 1'b1;
        end
    end

    mpx_regfile_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_bank0 (
        .clk     (clk_i),
        .wr_en   (b0_we),
        .wr_addr (b0_addr),
        .wr_data (b0_data),
        .rd_addr (rd_addr_i),
        .rd_data (b0_rd)
    );

    mpx_regfile_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_bank1 (
        .clk     (clk_i),
        .wr_en   (wr1_ok),
        .wr_addr (wr1_addr_i),
        .wr_data (wr1_data_i),
        .rd_addr (rd_addr_i),
        .rd_data (b1_rd)
    );

    for (genvar n = 0; n < NUM_RD; n++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] arr;
        logic [DATA_W-1:0] val;

        assign ra  = rd_addr_i[n*ADDR_W +: ADDR_W];
        assign arr = lvt[ra] ? b1_rd[n*DATA_W +: DATA_W] : b0_rd[n*DATA_W +: DATA_W];

        // Read select: bypass (port 1 preferred), then masking for the zero
        // register and for the not-ready window.
        always_comb begin
            val = arr;
            if (BYP_EN) begin
                if (wr1_ok && (wr1_addr_i == ra)) begin
                    val = wr1_data_i;
                end else if (wr0_ok && (wr0_addr_i == ra)) begin
                    val = wr0_data_i;
                end
            end
            if (!ready || is_zero_reg(ZERO_EN, |ra)) begin
                val = '0;
            end
        end

        assign rd_data_o[n*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_mpx_regfile_mp.sv
// Directed + table-driven bench for mpx_regfile_mp. dut0 uses default
// parameters; dut1..dut3 share one write stream at ADDR_W=4 with
// NUM_RD = 3, 1, 4 and are checked against a simple array model.
module tb_mpx_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut0: DATA_W 32, ADDR_W 5, NUM_RD 2, ZERO_REG 1, BYPASS 1
    logic        w0e, w1e;
    logic [4:0]  w0a, w1a;
    logic [31:0] w0d, w1d;
    logic [9:0]  ra0;
    logic [63:0] rd0;
    logic        busy0;

    // shared writes for the ADDR_W=4 instances
    logic        x0e, x1e;
    logic [3:0]  x0a, x1a;
    logic [31:0] x0d, x1d;
    logic [11:0]  ra1;
    logic [95:0]  rd1;
    logic [3:0]   ra2;
    logic [31:0]  rd2;
    logic [15:0]  ra3;
    logic [127:0] rd3;
    logic busy1, busy2, busy3;

    mpx_regfile_mp dut0 (
        .clk_i(clk), .rst_i(rst),
        .wr0_en_i(w0e), .wr0_addr_i(w0a), .wr0_data_i(w0d),
        .wr1_en_i(w1e), .wr1_addr_i(w1a), .wr1_data_i(w1d),
        .rd_addr_i(ra0), .rd_data_o(rd0), .init_busy_o(busy0));

    mpx_regfile_mp #(.ADDR_W(4), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .wr0_en_i(x0e), .wr0_addr_i(x0a), .wr0_data_i(x0d),
        .wr1_en_i(x1e), .wr1_addr_i(x1a), .wr1_data_i(x1d),
        .rd_addr_i(ra1), .rd_data_o(rd1), .init_busy_o(busy1));

    mpx_regfile_mp #(.ADDR_W(4), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .wr0_en_i(x0e), .wr0_addr_i(x0a), .wr0_data_i(x0d),
        .wr1_en_i(x1e), .wr1_addr_i(x1a), .wr1_data_i(x1d),
        .rd_addr_i(ra2), .rd_data_o(rd2), .init_busy_o(busy2));

    mpx_regfile_mp #(.ADDR_W(4), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .wr0_en_i(x0e), .wr0_addr_i(x0a), .wr0_data_i(x0d),
        .wr1_en_i(x1e), .wr1_addr_i(x1a), .wr1_data_i(x1d),
        .rd_addr_i(ra3), .rd_data_o(rd3), .init_busy_o(busy3));

    typedef struct {
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [14];
    logic [31:0] m [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_byp(input logic [3:0] a);
        if (a == 4'd0) return 32'h0;
        if (x1e && x1a == a) return x1d;
        if (x0e && x0a == a) return x0d;
        return m[a];
    endfunction

    initial begin
        int n0, n1, n2, n3, n;
        logic [4:0] a5;
        logic [3:0] a4;

        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222};
        tbl[4]  = '{1'b1, 5'd7,  32'h33333333, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h33333333, 32'h33333333};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h33333333, 32'h33333333};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h33333333};
        tbl[8]  = '{1'b1, 5'd10, 32'h12345678, 1'b1, 5'd9,  32'hCAFEF00D, 5'd10, 5'd9,  32'h12345678, 32'hCAFEF00D};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 32'hCAFEF00D, 32'h12345678};
        tbl[10] = '{1'b1, 5'd9,  32'h00000001, 1'b0, 5'd0,  32'h0,        5'd9,  5'd31, 32'h00000001, 32'h0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 32'h00000001, 32'h12345678};
        tbl[12] = '{1'b1, 5'd31, 32'h0,        1'b1, 5'd31, 32'h0BADF00D, 5'd31, 5'd9,  32'h0BADF00D, 32'h00000001};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h0BADF00D, 32'h0BADF00D};

        w0e = 1'b0; w0a = '0; w0d = '0; w1e = 1'b0; w1a = '0; w1d = '0;
        x0e = 1'b0; x0a = '0; x0d = '0; x1e = 1'b0; x1a = '0; x1d = '0;
        ra0 = '0; ra1 = '0; ra2 = '0; ra3 = '0;

        // --- reset held 3 cycles, then timed clear ---
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy0", {31'd0, busy0}, 32'd1);
            chk("rst_rd0", rd0[31:0], 32'h0);
        end
        rst = 1'b0;
        n0 = 0; n1 = 0; n2 = 0; n3 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!busy0 && n0 == 0) n0 = i;
            if (!busy1 && n1 == 0) n1 = i;
            if (!busy2 && n2 == 0) n2 = i;
            if (!busy3 && n3 == 0) n3 = i;
        end
        chk("clear_len_d32", n0, 32'd32);
        chk("clear_len_d16_rd3", n1, 32'd16);
        chk("clear_len_d16_rd1", n2, 32'd16);
        chk("clear_len_d16_rd4", n3, 32'd16);

        for (int a = 0; a < 32; a++) begin
            a5 = 5'(a);
            ra0 = {a5, a5};
            #1;
            chk("clear_rd0_p0", rd0[31:0], 32'h0);
            chk("clear_rd0_p1", rd0[63:32], 32'h0);
        end
        for (int a = 0; a < 16; a++) begin
            a4 = 4'(a);
            ra1 = {a4, a4, a4}; ra2 = a4; ra3 = {a4, a4, a4, a4};
            #1;
            for (int p = 0; p < 3; p++) chk("clear_rd1", rd1[p*32 +: 32], 32'h0);
            chk("clear_rd2", rd2, 32'h0);
            for (int p = 0; p < 4; p++) chk("clear_rd3", rd3[p*32 +: 32], 32'h0);
        end

        // --- dut0 directed table: bypass, collision, zero register ---
        for (int i = 0; i < 14; i++) begin
            w0e = tbl[i].w0e; w0a = tbl[i].w0a; w0d = tbl[i].w0d;
            w1e = tbl[i].w1e; w1a = tbl[i].w1a; w1d = tbl[i].w1d;
            ra0 = {tbl[i].r1, tbl[i].r0};
            #1;
            chk($sformatf("vec%0d_p0", i), rd0[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_p1", i), rd0[63:32], tbl[i].e1);
            tick();
        end
        w0e = 1'b0; w1e = 1'b0;

        // --- mid-clear reset ---
        w0e = 1'b1; w0a = 5'd31; w0d = 32'hA5A5A5A5;
        tick();
        w0e = 1'b0; ra0 = {5'd31, 5'd31};
        #1;
        chk("preload31", rd0[31:0], 32'hA5A5A5A5);
        rst = 1'b1;
        #1;
        chk("rst_ready_busy", {31'd0, busy0}, 32'd1);
        chk("rst_ready_rd", rd0[31:0], 32'h0);
        tick();
        rst = 1'b0;
        w0e = 1'b1; w0a = 5'd31; w0d = 32'h0BAD0BAD;
        for (int i = 0; i < 20; i++) tick();
        chk("midclr_busy", {31'd0, busy0}, 32'd1);
        chk("midclr_rd", rd0[63:32], 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy0 && n < 100) begin
            tick();
            n++;
        end
        w0e = 1'b0;
        chk("restart_len", n, 32'd32);
        #1;
        chk("restart_rd31", rd0[31:0], 32'h0);

        // --- ADDR_W=4 instances: directed latency checks ---
        for (int a = 0; a < 16; a++) m[a] = 32'h0;
        x0e = 1'b1; x0a = 4'd5; x0d = 32'hDEADBEEF;
        ra1 = {4'd0, 4'd0, 4'd5}; ra2 = 4'd5; ra3 = {4'd0, 4'd0, 4'd0, 4'd5};
        #1;
        chk("nobyp_same", rd1[31:0], 32'h0);
        chk("byp_same", rd3[31:0], 32'hDEADBEEF);
        tick();
        m[5] = 32'hDEADBEEF;
        x0e = 1'b0; x1e = 1'b1; x1a = 4'd0; x1d = 32'hFFFFFFFF;
        #1;
        chk("nobyp_next", rd2, 32'hDEADBEEF);
        ra1 = {4'd0, 4'd0, 4'd0}; ra3 = {4'd0, 4'd0, 4'd0, 4'd0};
        #1;
        chk("zr0_same", rd1[31:0], 32'h0);
        chk("zr1_same", rd3[31:0], 32'h0);
        tick();
        m[0] = 32'hFFFFFFFF;
        x1e = 1'b0;
        #1;
        chk("zr0_next", rd1[31:0], 32'hFFFFFFFF);
        chk("zr1_next", rd3[31:0], 32'h0);

        // --- random dual writes against array model ---
        for (int c = 0; c < 150; c++) begin
            x0e = 1'($urandom_range(0, 1)); x0a = 4'($urandom_range(0, 15)); x0d = $urandom;
            x1e = 1'($urandom_range(0, 1)); x1a = 4'($urandom_range(0, 15)); x1d = $urandom;
            if (c % 8 == 0) x1a = x0a;
            ra1 = 12'($urandom); ra2 = 4'($urandom); ra3 = 16'($urandom);
            #1;
            for (int p = 0; p < 3; p++) chk("rand_rd3", rd1[p*32 +: 32], m[ra1[p*4 +: 4]]);
            chk("rand_rd1", rd2, m[ra2]);
            for (int p = 0; p < 4; p++) chk("rand_rd4", rd3[p*32 +: 32], model_byp(ra3[p*4 +: 4]));
            tick();
            if (x0e) m[x0a] = x0d;
            if (x1e) m[x1a] = x1d;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
